// File: rtl/line_word_sequencer_if.sv
// Bundle of every non-clock signal of the line/word sequencer.
// The slave modport is the sequencer's view: it accepts line requests from
// the arbiter and drives the word-wide memory bus. The master modport is the
// surrounding environment, which is the arbiter plus the memory.
interface line_word_sequencer_if;
    // Arbiter side: one 256-bit line per transaction
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         we_i;
    logic         rd_i;
    logic [255:0] data_o;
    logic         ack_o;
    logic         hw_page_fault_o;
    logic         busy_o;

    // Memory side: eight 32-bit beats per line
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_data_o;
    logic [31:0]  mem_data_i;
    logic         mem_we_o;
    logic         mem_rd_o;
    logic         mem_ack_i;
    logic         mem_err_i;

    modport slave (
        input  addr_i, data_i, we_i, rd_i,
        output data_o, ack_o, hw_page_fault_o, busy_o,
        output mem_addr_o, mem_data_o, mem_we_o, mem_rd_o,
        input  mem_data_i, mem_ack_i, mem_err_i
    );

    modport master (
        output addr_i, data_i, we_i, rd_i,
        input  data_o, ack_o, hw_page_fault_o, busy_o,
        input  mem_addr_o, mem_data_o, mem_we_o, mem_rd_o,
        output mem_data_i, mem_ack_i, mem_err_i
    );
endinterface

// File: rtl/line_word_sequencer.sv
// Splits one 256-bit line transaction into eight 32-bit memory beats
// (beat 0 is the least significant word) and reassembles read lines.
// Completion is a one-cycle ack; bus errors and beat timeouts raise
// hw_page_fault together with that ack so the arbiter is always released.
module line_word_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    line_word_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    // Watchdog value at which a waiting beat gives up; unused when TIMEOUT is 0
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          r_state;
    logic [2:0]      r_beat;
    logic [TO_W-1:0] r_wd;
    logic            r_write;
    logic [26:0]     r_lineAddr;
    logic [255:0]    r_wline;
    logic [255:0]    r_rline;
    logic            r_ack;
    logic            r_fault;
    logic [31:0]     r_memAddr;
    logic [31:0]     r_memData;
    logic            r_memWe;
    logic            r_memRd;

    logic [2:0]      w_nextBeat;
    logic [7:0]      w_curBit;
    logic [7:0]      w_nextBit;
    logic            w_unused;

    // Beats wrap within the line, so the 3-bit counter simply rolls over
    assign w_nextBeat = r_beat + 3'd1;
    assign w_curBit   = {r_beat, 5'd0};
    assign w_nextBit  = {w_nextBeat, 5'd0};

    // Byte offset within the line plays no part in sequencing
    assign w_unused   = ^bus.addr_i[4:0];

    // Sequencer state machine; every bus-facing output is a register here so
    // the memory side never sees decode glitches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_wd       <= '0;
            r_write    <= 1'b0;
            r_lineAddr <= '0;
            r_wline    <= '0;
            r_rline    <= '0;
            r_ack      <= 1'b0;
            r_fault    <= 1'b0;
            r_memAddr  <= '0;
            r_memData  <= '0;
            r_memWe    <= 1'b0;
            r_memRd    <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.we_i || bus.rd_i) begin
                        r_state    <= BEAT;
                        r_lineAddr <= bus.addr_i[31:5];
                        r_wline    <= bus.data_i;
                        r_write    <= bus.we_i;
                        r_beat     <= '0;
                        r_wd       <= '0;
                        r_memAddr  <= {bus.addr_i[31:5], 5'd0};
                        r_memData  <= bus.we_i ? bus.data_i[31:0] : 32'd0;
                        r_memWe    <= bus.we_i;
                        r_memRd    <= !bus.we_i;
                    end
                end
                BEAT: begin
                    if (bus.mem_err_i) begin
                        r_state   <= DONE;
                        r_ack     <= 1'b1;
                        r_fault   <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memRd   <= 1'b0;
                        r_memAddr <= '0;
                        r_memData <= '0;
                    end else if (bus.mem_ack_i) begin
                        r_wd <= '0;
                        if (!r_write) begin
                            r_rline[w_curBit +: 32] <= bus.mem_data_i;
                        end
                        if (r_beat == 3'd7) begin
                            r_state   <= DONE;
                            r_ack     <= 1'b1;
                            r_memWe   <= 1'b0;
                            r_memRd   <= 1'b0;
                            r_memAddr <= '0;
                            r_memData <= '0;
                        end else begin
                            r_beat    <= w_nextBeat;
                            r_memAddr <= {r_lineAddr, w_nextBeat, 2'b00};
                            r_memData <= r_write ? r_wline[w_nextBit +: 32] : 32'd0;
                        end
                    end else if ((TIMEOUT != 0) && (r_wd == TO_LAST)) begin
                        r_state   <= DONE;
                        r_ack     <= 1'b1;
                        r_fault   <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memRd   <= 1'b0;
                        r_memAddr <= '0;
                        r_memData <= '0;
                    end else begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_o          = r_rline;
    assign bus.ack_o           = r_ack;
    assign bus.hw_page_fault_o = r_fault;
    assign bus.busy_o          = (r_state != IDLE);
    assign bus.mem_addr_o      = r_memAddr;
    assign bus.mem_data_o      = r_memData;
    assign bus.mem_we_o        = r_memWe;
    assign bus.mem_rd_o        = r_memRd;
endmodule

// File: doc/line_word_sequencer.md
Name: line_word_sequencer

Overview:
- Sits below the cache/instruction-fetch arbiter. Takes one 256-bit line transaction from it and turns it into eight sequential 32-bit beats on the word-wide memory bus.
- Returns the assembled line on reads.
- Signals completion with a 1-cycle ack pulse. Reports bus errors and beat timeouts as hw_page_fault, together with the ack, so the arbiter always releases.

Parameters:
- TIMEOUT, 1024: maximum cycles one beat may wait for mem_ack_i before the line faults; 0 disables the watchdog.
- TO_W, 16: width of the watchdog counter; TIMEOUT must be less than 2^TO_W.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- addr_i  in  32  line address; bits [4:0] ignored.
- data_i  in  256  write line.
- we_i  in  1  write request, level, held until ack_o.
- rd_i  in  1  read request, level, held until ack_o.
- data_o  out  256  read line.
- ack_o  out  1  1-cycle completion pulse.
- hw_page_fault_o  out  1  1-cycle fault pulse, coincident with ack_o.
- busy_o  out  1  high in any state other than IDLE.
- mem_addr_o  out  32  word address.
- mem_data_o  out  32  write word.
- mem_data_i  in  32  read word.
- mem_we_o  out  1  write strobe.
- mem_rd_o  out  1  read strobe.
- mem_ack_i  in  1  beat complete.
- mem_err_i  in  1  bus error, terminates the line.

Behaviour:

Reset:
- rst=0 forces state IDLE, beat=0, watchdog=0 and a latched write flag of 0, immediately and without waiting for clk.
- All outputs are 0 during reset, including data_o.
- A reset mid-line drops the strobes at once and never produces ack_o. Beats already written are not rolled back.

States:
- IDLE
- BEAT
- DONE

IDLE:
- If we_i or rd_i is high at the edge, latch the following and go to BEAT:
  - addr_i[31:5]
  - data_i
  - write flag = we_i (we_i wins if both are high)
  - beat=0, watchdog=0, fault=0
- Otherwise stay in IDLE.

BEAT:
- mem_addr_o = {line_addr[31:5], beat[2:0], 2'b00}.
- mem_we_o = write flag; mem_rd_o = not write flag. Exactly one strobe is high.
- mem_data_o = wline[32*beat+31 : 32*beat]; it is 0 on reads.
- Beat ordering: beat k maps to line bits [32k+31:32k], so beat 0 is the LSW.
- Strobes stay high continuously across beats. The address and data advance on the edge at which mem_ack_i=1 is sampled.
- The memory may ack in the first cycle a strobe is seen. Each sampled ack consumes exactly one beat.
- On a read ack, capture mem_data_i into data_o slice [beat].
- mem_ack_i=1 on beat 7 → DONE, fault=0.
- mem_err_i=1 sampled in any BEAT cycle → DONE, fault=1. mem_err_i has priority over a simultaneous mem_ack_i, and that word is not captured.
- Watchdog:
  - Clears on every ack; otherwise increments each BEAT cycle.
  - With TIMEOUT≠0 and no ack, reaching TIMEOUT-1 → DONE, fault=1.

DONE:
- Strobes are 0.
- ack_o=1 for exactly one cycle; hw_page_fault_o=fault.
- Next state is always IDLE. The requester drops its request on the ack edge, so IDLE never re-accepts the finished request.
- After a fault, the partially captured read words are present in data_o and are undefined for the requester.

data_o:
- Holds its value from DONE until the next read's beat-0 capture.
- Writes never modify data_o.

Latency:
- Request sampled at edge E0; strobe high in cycle 1.
- With mem_ack_i held high: beats complete at E1..E8 and ack_o is high in cycle 9.
- Total latency is 9 + the sum of memory wait cycles.

Arithmetic:
- The beat counter is 3 bits.
- The line address is not incremented across a 32-byte boundary; beats wrap within the line.

Test Plan:
- Read, addr_i=0x0000_1234, memory acks every cycle and returns word k = 0xA000_0000+k → mem_addr_o steps 0x1220, 0x1224 … 0x123C; ack_o in cycle 9; data_o[31:0]=0xA000_0000, data_o[255:224]=0xA000_0007; hw_page_fault_o=0.
- Write with we_i=rd_i=1, data_i word k = 0x1111_1111*k, memory inserts 2 wait cycles per beat → only mem_we_o high; mem_data_o sequence 0x0, 0x1111_1111 … 0x7777_7777; ack_o at cycle 25; data_o unchanged.
- mem_err_i=1 together with mem_ack_i on beat 3 of a read → no beat 4 strobe; next cycle ack_o=1 and hw_page_fault_o=1; then IDLE.
- TIMEOUT=4, memory never acks beat 0 → strobe high for 4 cycles; ack_o and fault in cycle 5; busy_o low in cycle 6.
- rst pulled low asynchronously during beat 5 of a write → mem_we_o, busy_o and data_o go to 0 before the next clk edge; no ack_o; a new read after release starts at beat 0.
- Two back-to-back reads where the requester re-asserts rd_i in the cycle after ack_o → exactly one IDLE cycle between lines; the second line's first strobe appears in cycle 11.
